// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage scoreboard interlock with branch flush and stall counter; HAZARD_WB_BYPASS_EN lets a same-cycle writeback clear a hazard
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       Op,
  input  logic [4:0]       Ra,
  input  logic [4:0]       Rb,
  input  logic [4:0]       Rd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush,
  output logic             issue,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t state, state_n;
  logic [2:0] fcnt;
  logic ra_used, rb_used, rd_wr, hazard;
  logic [31:0] busy_eff, set_m, clr_m;
  // operand usage decode and hazard detection against the effective scoreboard
  always_comb begin
    ra_used = !(Op == 7'b0110111 || Op == 7'b0010111 || Op == 7'b1101111);
    rb_used = Op == 7'b0110011 || Op == 7'b0100011 || Op == 7'b1100011;
    rd_wr = !(Op == 7'b0100011 || Op == 7'b1100011);
`ifdef HAZARD_WB_BYPASS_EN
    busy_eff = wb_valid ? busy & ~(32'd1 << wb_rd) : busy;
`else
    busy_eff = busy;
`endif
    hazard = (ra_used && busy_eff[Ra]) || (rb_used && busy_eff[Rb]) ||
             (rd_wr && Rd != 5'd0 && busy_eff[Rd]);
    set_m = (issue && rd_wr && Rd != 5'd0) ? 32'd1 << Rd : 32'd0;
    clr_m = (wb_valid && wb_rd != 5'd0) ? 32'd1 << wb_rd : 32'd0;
  end
  // next state and zero-latency pipeline controls; branch outranks everything but reset
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    issue = 1'b0;
    state_n = RUN;
    if (rst) state_n = RUN;
    else if (br_taken) begin
      flush = 1'b1;
      state_n = FLUSH;
    end else if (state == FLUSH) begin
      flush = 1'b1;
      state_n = fcnt <= 3'd1 ? RUN : FLUSH;
    end else if (id_valid) begin
      stall = hazard;
      issue = !hazard;
      state_n = hazard ? STALL : RUN;
    end
  end
  // state, flush countdown, scoreboard (set beats clear, x0 never busy) and saturating stall count
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt <= 3'd0;
      busy <= 32'd0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      fcnt <= br_taken ? 3'(FLUSH_CYCLES) : state == FLUSH ? fcnt - 3'd1 : fcnt;
      busy <= ((busy & ~clr_m) | set_m) & ~32'd1;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam logic [6:0] OP_R = 7'b0110011, OP_S = 7'b0100011, OP_I = 7'b0010011;
  logic clk = 1'b0, rst = 1'b1, id_valid = 1'b0, wb_valid = 1'b0, br_taken = 1'b0;
  logic [6:0] Op = OP_I;
  logic [4:0] Ra = 5'd0, Rb = 5'd0, Rd = 5'd0, wb_rd = 5'd0;
  logic stall, flush, issue;
  logic [31:0] busy;
  logic [15:0] stall_cnt;
  int checks = 0, errors = 0, exp_sc = 0;
  hazard_ctrl dut (.clk(clk), .rst(rst), .id_valid(id_valid), .Op(Op), .Ra(Ra), .Rb(Rb), .Rd(Rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .br_taken(br_taken), .stall(stall), .flush(flush),
    .issue(issue), .busy(busy), .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] d, input logic wv, input logic [4:0] wr, input logic br);
    id_valid = v; Op = op; Ra = a; Rb = b; Rd = d; wb_valid = wv; wb_rd = wr; br_taken = br;
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic ctl(input string tag, input logic s, input logic f, input logic i);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".flush"}, 32'(flush), 32'(f));
    chk({tag, ".issue"}, 32'(issue), 32'(i));
  endtask
  initial begin
    drv(1, OP_I, 1, 0, 7, 1, 3, 1);
    ctl("rst_outs", 0, 0, 0);
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    rst = 1'b0;
    drv(1, OP_R, 1, 3, 2, 0, 0, 0);
    ctl("raw_first", 0, 0, 1);
    cyc();
    chk("busy_x2", busy, 32'h4);
    drv(1, OP_R, 2, 4, 6, 0, 0, 0);
    ctl("raw_stall", 1, 0, 0);
    cyc(); exp_sc++;
    chk("stall_cnt1", 32'(stall_cnt), 32'(exp_sc));
    ctl("raw_stall2", 1, 0, 0);
    cyc(); exp_sc++;
    chk("stall_cnt2", 32'(stall_cnt), 32'(exp_sc));
    drv(1, OP_R, 2, 4, 6, 1, 2, 0);
`ifdef HAZARD_WB_BYPASS_EN
    ctl("wb_bypass", 0, 0, 1);
    cyc();
`else
    ctl("wb_nobypass", 1, 0, 0);
    cyc(); exp_sc++;
    chk("busy_cleared", busy, 0);
    drv(1, OP_R, 2, 4, 6, 0, 0, 0);
    ctl("wb_late_issue", 0, 0, 1);
    cyc();
`endif
    chk("busy_x6", busy, 32'h40);
    chk("stall_cnt3", 32'(stall_cnt), 32'(exp_sc));
    drv(0, OP_R, 2, 4, 6, 1, 6, 0);
    ctl("idle", 0, 0, 0);
    cyc();
    chk("busy_clr6", busy, 0);
    drv(1, OP_I, 0, 0, 2, 0, 0, 0);
    cyc();
    drv(1, OP_S, 4, 2, 9, 0, 0, 0);
    ctl("store_rb_haz", 1, 0, 0);
    cyc(); exp_sc++;
    drv(0, OP_S, 4, 2, 9, 1, 2, 0);
    cyc();
    drv(1, OP_S, 4, 2, 9, 0, 0, 0);
    ctl("store_issue", 0, 0, 1);
    cyc();
    chk("store_no_rd", busy, 0);
    chk("stall_cnt4", 32'(stall_cnt), 32'(exp_sc));
    drv(1, OP_I, 1, 0, 0, 0, 0, 0);
    cyc();
    chk("rd0_busy", busy, 0);
    drv(1, OP_R, 0, 0, 0, 0, 0, 0);
    ctl("ra0_issue", 0, 0, 1);
    drv(1, OP_I, 1, 0, 5, 1, 5, 0);
    ctl("set_clr_issue", 0, 0, 1);
    cyc();
    chk("set_wins", busy, 32'h20);
    drv(1, OP_I, 1, 0, 7, 0, 0, 1);
    ctl("br_pulse", 0, 1, 0);
    cyc();
    drv(1, OP_I, 1, 0, 7, 1, 5, 0);
    ctl("flush1", 0, 1, 0);
    cyc();
    chk("flush_wb_clr", busy, 0);
    drv(1, OP_I, 1, 0, 7, 0, 0, 0);
    ctl("flush2", 0, 1, 0);
    cyc();
    ctl("flush_done", 0, 0, 1);
    drv(0, OP_I, 1, 0, 7, 0, 0, 1);
    cyc();
    drv(0, OP_I, 1, 0, 7, 0, 0, 0);
    ctl("re_f1", 0, 1, 0);
    drv(0, OP_I, 1, 0, 7, 0, 0, 1);
    ctl("re_pulse", 0, 1, 0);
    cyc();
    drv(1, OP_I, 1, 0, 7, 0, 0, 0);
    ctl("reload1", 0, 1, 0);
    cyc();
    ctl("reload2", 0, 1, 0);
    cyc();
    ctl("reload_done", 0, 0, 1);
    chk("flush_no_set", busy, 0);
    drv(1, OP_I, 0, 0, 2, 0, 0, 0);
    cyc();
    drv(1, OP_I, 0, 0, 5, 0, 0, 0);
    cyc();
    chk("busy_24", busy, 32'h24);
    drv(1, OP_R, 2, 5, 8, 0, 0, 0);
    ctl("pre_rst_stall", 1, 0, 0);
    cyc();
    rst = 1'b1;
    drv(1, OP_R, 2, 5, 8, 1, 2, 1);
    ctl("rst_mid_stall", 0, 0, 0);
    cyc();
    rst = 1'b0;
    drv(1, OP_R, 2, 5, 8, 0, 0, 0);
    chk("rst_busy2", busy, 0);
    chk("rst_cnt2", 32'(stall_cnt), 0);
    ctl("rst_run", 0, 0, 1);
    drv(1, OP_I, 0, 0, 2, 0, 0, 0);
    cyc();
    drv(1, OP_R, 2, 0, 3, 0, 0, 0);
    repeat (65539) cyc();
    chk("sat_cnt", 32'(stall_cnt), 32'hffff);
    ctl("sat_still_stall", 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush stays asserted after a taken branch (legal 1..7).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  a valid instruction is present in decode.
REQ-006 Op  input  7  opcode of the decode instruction.
REQ-007 Ra  input  5  source register A index; Rb  input  5  source register B index.
REQ-008 Rd  input  5  destination register index.
REQ-009 wb_valid  input  1  a register write completes this cycle; wb_rd  input  5  its destination index.
REQ-010 br_taken  input  1  single-cycle pulse; a branch or jump resolved taken in execute.
REQ-011 stall  output  1  hold PC and IF/ID register this cycle.
REQ-012 flush  output  1  squash IF/ID contents this cycle.
REQ-013 issue  output  1  decode instruction advances this cycle.
REQ-014 busy  output  32  scoreboard; bit n set = write to xn pending.
REQ-015 stall_cnt  output  CNT_W  saturating count of cycles with stall=1.

Function
REQ-016 Source use SHALL be decoded from Op: Ra used for all opcodes except 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL); Rb used only for 0110011, 0100011 and 1100011.
REQ-017 Rd write SHALL be decoded from Op: writes for all opcodes except 0100011 (store) and 1100011 (branch).
REQ-018 busy[0] SHALL always read 0; no hazard is ever raised on x0.
REQ-019 The FSM SHALL have states RUN, STALL and FLUSH, encoded in at most 2 bits.
REQ-020 hazard SHALL be (Ra used and busy_eff[Ra]) or (Rb used and busy_eff[Rb]) or (Rd written, Rd!=0 and busy_eff[Rd]); WAW is included.
REQ-021 In RUN or STALL with id_valid=1: hazard=1 gives stall=1, issue=0, next state STALL; hazard=0 gives issue=1, stall=0, next state RUN.
REQ-022 With id_valid=0 and not in FLUSH: stall=0, issue=0, next state RUN.
REQ-023 On issue with Rd written and Rd!=0, busy[Rd] SHALL be set at the next edge.
REQ-024 On wb_valid=1 with wb_rd!=0, busy[wb_rd] SHALL be cleared at the next edge.
REQ-025 If set and clear target the same bit in one cycle, set SHALL win.
REQ-026 br_taken=1 in any state SHALL load the flush counter with FLUSH_CYCLES and enter FLUSH at the next edge; in that same cycle flush=1, issue=0 and stall=0.
REQ-027 In FLUSH: flush=1, issue=0, stall=0 and no scoreboard set; the counter decrements each cycle and the FSM returns to RUN after the cycle in which it reaches 1.
REQ-028 br_taken=1 while in FLUSH SHALL reload the counter to FLUSH_CYCLES.
REQ-029 Scoreboard clears from writeback SHALL continue during STALL and FLUSH.
REQ-030 stall, flush and issue SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-031 stall_cnt SHALL increment by 1 on each cycle with stall=1 and hold at all-ones; it never wraps.

Reset
REQ-032 With rst=1 at an edge: state=RUN, busy=0, flush counter=0 and stall_cnt=0.
REQ-033 While rst=1, stall, flush and issue SHALL be 0.
REQ-034 rst SHALL override every other input in the same cycle, including br_taken and wb_valid, and SHALL abort any stall or flush in progress.

Configuration
REQ-035 With macro HAZARD_WB_BYPASS_EN defined: busy_eff = busy with bit wb_rd masked when wb_valid=1, so a same-cycle writeback resolves the hazard immediately.
REQ-036 Without HAZARD_WB_BYPASS_EN: busy_eff = busy, so the hazard resolves one cycle after the writeback.

Verification
REQ-037 Issue Op=0110011 with Rd=2, then Op=0110011 with Ra=2 and Rb=4 -> second instruction stalls and stall_cnt increments each stall cycle; wb_valid with wb_rd=2 -> issue in that cycle with the macro, one cycle later without it.
REQ-038 Op=0100011 with Ra=4, Rb=2 while busy[2]=1 -> stall=1; the same Op while only busy[4]=0 and busy[2]=0 -> issue=1 and busy unchanged (store writes no Rd).
REQ-039 br_taken pulse with FLUSH_CYCLES=2 -> flush=1 for 3 cycles (pulse cycle plus 2 FLUSH cycles) and issue=0 throughout; a second pulse during FLUSH extends flush by a reload.
REQ-040 Issue Rd=0 followed by Ra=0 -> busy stays 0 and there is no stall; issue Rd=5 with wb_rd=5 in the same cycle -> busy[5]=1 afterwards.
REQ-041 Assert rst mid-STALL with busy=32'h0000_0024 -> next cycle busy=0, state RUN and stall_cnt=0; force 2^CNT_W+3 stall cycles -> stall_cnt holds at all-ones.
